// File: rtl/alu_pkg.sv
// alu_pkg: ALU SELECT codes, opcode/funct7 constants and the ID/EX register layout.
package alu_pkg;
  localparam int XLEN  = 32;
  localparam int SEL_W = 5;
  typedef logic [SEL_W-1:0] alu_sel_t;
  localparam alu_sel_t SEL_ADD    = 5'b00000;
  localparam alu_sel_t SEL_SLL    = 5'b00001;
  localparam alu_sel_t SEL_SLT    = 5'b00010;
  localparam alu_sel_t SEL_SLTU   = 5'b00011;
  localparam alu_sel_t SEL_XOR    = 5'b00100;
  localparam alu_sel_t SEL_SRL    = 5'b00101;
  localparam alu_sel_t SEL_OR     = 5'b00110;
  localparam alu_sel_t SEL_AND    = 5'b00111;
  localparam alu_sel_t SEL_MUL    = 5'b01000;
  localparam alu_sel_t SEL_MULH   = 5'b01001;
  localparam alu_sel_t SEL_MULHSU = 5'b01010;
  localparam alu_sel_t SEL_MULHU  = 5'b01011;
  localparam alu_sel_t SEL_DIV    = 5'b01100;
  localparam alu_sel_t SEL_REM    = 5'b01101;
  localparam alu_sel_t SEL_DIVU   = 5'b01110;
  localparam alu_sel_t SEL_REMU   = 5'b01111;
  localparam alu_sel_t SEL_SUB    = 5'b10000;
  localparam alu_sel_t SEL_SRA    = 5'b10001;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;
  typedef struct packed {
    logic            valid;
    alu_sel_t        sel;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } id_ex_t;
  function automatic alu_sel_t base_sel(input logic [2:0] f3);
    case (f3)
      3'd0:    return SEL_ADD;
      3'd1:    return SEL_SLL;
      3'd2:    return SEL_SLT;
      3'd3:    return SEL_SLTU;
      3'd4:    return SEL_XOR;
      3'd5:    return SEL_SRL;
      3'd6:    return SEL_OR;
      default: return SEL_AND;
    endcase
  endfunction
  function automatic alu_sel_t muldiv_sel(input logic [2:0] f3);
    case (f3)
      3'd0:    return SEL_MUL;
      3'd1:    return SEL_MULH;
      3'd2:    return SEL_MULHSU;
      3'd3:    return SEL_MULHU;
      3'd4:    return SEL_DIV;
      3'd5:    return SEL_DIVU;
      3'd6:    return SEL_REM;
      default: return SEL_REMU;
    endcase
  endfunction
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: combinational RV32I/M ALU decode; M ops only with RV32M_DECODE_EN defined.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output alu_sel_t        sel,
  output logic [XLEN-1:0] data1,
  output logic [XLEN-1:0] data2,
  output logic            illegal,
  output logic [4:0]      rd
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  alu_sel_t sel_r;
  logic [XLEN-1:0] d1_r, d2_r;
  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign rd  = instr[11:7];
  always_comb begin
    sel_r   = SEL_ADD;
    d1_r    = '0;
    d2_r    = '0;
    illegal = 1'b0;
    if (opc == OPC_OP) begin
      d1_r = rs1_data;
      d2_r = rs2_data;
      if (f7 == F7_BASE) sel_r = base_sel(f3);
      else if (f7 == F7_ALT && f3 == 3'd0) sel_r = SEL_SUB;
      else if (f7 == F7_ALT && f3 == 3'd5) sel_r = SEL_SRA;
`ifdef RV32M_DECODE_EN
      else if (f7 == F7_MULDIV) sel_r = muldiv_sel(f3);
`endif
      else illegal = 1'b1;
    end else if (opc == OPC_OP_IMM) begin
      d1_r    = rs1_data;
      d2_r    = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
      sel_r   = (f3 == 3'd5 && f7 == F7_ALT) ? SEL_SRA : base_sel(f3);
      illegal = (f3 == 3'd1 && f7 != F7_BASE) || (f3 == 3'd5 && f7 != F7_BASE && f7 != F7_ALT);
    end else if (opc == OPC_LUI || opc == OPC_AUIPC) begin
      d1_r = (opc == OPC_AUIPC) ? pc : '0;
      d2_r = {instr[31:12], 12'b0};
    end else illegal = 1'b1;
  end
  // illegal encodings present a harmless ADD 0+0 to the ALU
  assign sel   = illegal ? SEL_ADD : sel_r;
  assign data1 = illegal ? '0 : d1_r;
  assign data2 = illegal ? '0 : d2_r;
endmodule

// File: rtl/alu_ctrl_id_ex.sv
// alu_ctrl_id_ex: ID/EX register for ALU control with flush > stall > load priority.
// M-extension decode is enabled by defining RV32M_DECODE_EN.
module alu_ctrl_id_ex
  import alu_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic             ID_VALID,
  input  logic [31:0]      ID_INSTR,
  input  logic [XLEN-1:0]  ID_PC,
  input  logic [XLEN-1:0]  ID_RS1_DATA,
  input  logic [XLEN-1:0]  ID_RS2_DATA,
  output logic             EX_VALID,
  output logic [SEL_W-1:0] EX_ALU_SELECT,
  output logic [XLEN-1:0]  EX_DATA1,
  output logic [XLEN-1:0]  EX_DATA2,
  output logic [4:0]       EX_RD,
  output logic             EX_REG_WRITE,
  output logic             EX_ILLEGAL,
  output logic [XLEN-1:0]  EX_PC
);
  id_ex_t ex_d, ex_q, dec;
  logic dec_ill;
  alu_op_decoder u_dec (
    .instr    (ID_INSTR),
    .pc       (ID_PC),
    .rs1_data (ID_RS1_DATA),
    .rs2_data (ID_RS2_DATA),
    .sel      (dec.sel),
    .data1    (dec.data1),
    .data2    (dec.data2),
    .illegal  (dec_ill),
    .rd       (dec.rd)
  );
  assign dec.valid     = ID_VALID;
  assign dec.reg_write = ID_VALID & ~dec_ill & (|dec.rd);
  assign dec.illegal   = ID_VALID & dec_ill;
  assign dec.pc        = ID_PC;
  always_comb ex_d = FLUSH ? '0 : STALL ? ex_q : dec;
  always_ff @(posedge CLK) begin
    if (RESET) ex_q <= '0;
    else ex_q <= ex_d;
  end
  assign EX_VALID      = ex_q.valid;
  assign EX_ALU_SELECT = ex_q.sel;
  assign EX_DATA1      = ex_q.data1;
  assign EX_DATA2      = ex_q.data2;
  assign EX_RD         = ex_q.rd;
  assign EX_REG_WRITE  = ex_q.reg_write;
  assign EX_ILLEGAL    = ex_q.illegal;
  assign EX_PC         = ex_q.pc;
endmodule

// File: tb/tb_alu_ctrl_id_ex.sv
// tb_alu_ctrl_id_ex: directed test-plan vectors plus randomized checks against a rule-level model.
module tb_alu_ctrl_id_ex;
  typedef struct packed {
    logic        v;
    logic [4:0]  sel;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
    logic [31:0] pc;
  } exp_t;
  logic clk = 0, rst = 1, stall = 0, flush = 0, id_valid = 0;
  logic [31:0] id_instr = 0, id_pc = 0, rs1 = 0, rs2 = 0;
  logic ex_valid, ex_rw, ex_ill;
  logic [4:0] ex_sel, ex_rd;
  logic [31:0] ex_d1, ex_d2, ex_pc;
  exp_t act, e;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_ctrl_id_ex dut (
    .CLK(clk), .RESET(rst), .STALL(stall), .FLUSH(flush), .ID_VALID(id_valid),
    .ID_INSTR(id_instr), .ID_PC(id_pc), .ID_RS1_DATA(rs1), .ID_RS2_DATA(rs2),
    .EX_VALID(ex_valid), .EX_ALU_SELECT(ex_sel), .EX_DATA1(ex_d1), .EX_DATA2(ex_d2),
    .EX_RD(ex_rd), .EX_REG_WRITE(ex_rw), .EX_ILLEGAL(ex_ill), .EX_PC(ex_pc)
  );
  assign act = {ex_valid, ex_sel, ex_d1, ex_d2, ex_rd, ex_rw, ex_ill, ex_pc};
  function automatic exp_t mk(logic v, int sel, logic [31:0] d1, logic [31:0] d2, int rd, logic rw, logic ill, logic [31:0] pc);
    exp_t r;
    r.v = v; r.sel = 5'(sel); r.d1 = d1; r.d2 = d2; r.rd = 5'(rd); r.rw = rw; r.ill = ill; r.pc = pc;
    return r;
  endfunction
  // Reference decode straight from the ISA rules; SELECT numbers are the ALU's code values.
  function automatic exp_t ref_dec(logic v, logic [31:0] i, logic [31:0] pc, logic [31:0] a, logic [31:0] b);
    int mtab[8] = '{8, 9, 10, 11, 12, 14, 13, 15};
    int f7 = int'(i[31:25]);
    int f3 = int'(i[14:12]);
    int sel = 0;
    bit bad = 0;
    logic [31:0] x = 0, y = 0;
    case (i[6:0])
      7'h33: begin
        x = a; y = b;
        if (f7 == 0) sel = f3;
        else if (f7 == 32 && f3 == 0) sel = 16;
        else if (f7 == 32 && f3 == 5) sel = 17;
        else if (f7 == 1) begin
`ifdef RV32M_DECODE_EN
          sel = mtab[f3];
`else
          bad = 1;
`endif
        end else bad = 1;
      end
      7'h13: begin
        x = a;
        sel = f3;
        y = (f3 == 1 || f3 == 5) ? {27'b0, i[24:20]} : {{20{i[31]}}, i[31:20]};
        if (f3 == 1 && f7 != 0) bad = 1;
        if (f3 == 5) begin
          if (f7 == 32) sel = 17;
          else if (f7 != 0) bad = 1;
        end
      end
      7'h37: y = {i[31:12], 12'b0};
      7'h17: begin x = pc; y = {i[31:12], 12'b0}; end
      default: bad = 1;
    endcase
    if (bad) begin sel = 0; x = 0; y = 0; end
    return mk(v, sel, x, y, int'(i[11:7]), v && !bad && i[11:7] != 0, v && bad, pc);
  endfunction
  task automatic drive(logic v, logic [31:0] i, logic [31:0] pc, logic [31:0] a, logic [31:0] b);
    id_valid = v; id_instr = i; id_pc = pc; rs1 = a; rs2 = b;
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst = 1; drive(1, 32'h002081B3, 32'h40, 5, 7);
    step(); step();
    checks++;
    if (act !== exp_t'(0)) begin errors++; $display("FAIL reset: got %h exp %h", act, exp_t'(0)); end
    rst = 0;
  endtask
  task automatic test_op();
    drive(1, 32'h002081B3, 32'h40, 5, 7); step();
    e = mk(1, 0, 5, 7, 3, 1, 0, 32'h40); checks++;
    if (act !== e) begin errors++; $display("FAIL add: got %h exp %h", act, e); end
    drive(1, 32'h40435293, 32'h44, 32'h80000000, 9); step();
    e = mk(1, 17, 32'h80000000, 4, 5, 1, 0, 32'h44); checks++;
    if (act !== e) begin errors++; $display("FAIL srai: got %h exp %h", act, e); end
    drive(1, 32'h40208033, 32'h48, 20, 3); step();
    e = mk(1, 16, 20, 3, 0, 0, 0, 32'h48); checks++;
    if (act !== e) begin errors++; $display("FAIL sub_x0: got %h exp %h", act, e); end
  endtask
  task automatic test_upper();
    drive(1, 32'h12345097, 32'h100, 1, 2); step();
    e = mk(1, 0, 32'h100, 32'h12345000, 1, 1, 0, 32'h100); checks++;
    if (act !== e) begin errors++; $display("FAIL auipc: got %h exp %h", act, e); end
    drive(1, 32'h12345137, 32'h104, 1, 2); step();
    e = mk(1, 0, 0, 32'h12345000, 2, 1, 0, 32'h104); checks++;
    if (act !== e) begin errors++; $display("FAIL lui: got %h exp %h", act, e); end
  endtask
  task automatic test_muldiv();
    drive(1, 32'h0220F233, 32'h108, 11, 22); step();
`ifdef RV32M_DECODE_EN
    e = mk(1, 15, 11, 22, 4, 1, 0, 32'h108);
`else
    e = mk(1, 0, 0, 0, 4, 0, 1, 32'h108);
`endif
    checks++;
    if (act !== e) begin errors++; $display("FAIL remu: got %h exp %h", act, e); end
  endtask
  task automatic test_illegal();
    drive(1, 32'h00002083, 32'h10C, 3, 4); step();
    e = mk(1, 0, 0, 0, 1, 0, 1, 32'h10C); checks++;
    if (act !== e) begin errors++; $display("FAIL load_valid: got %h exp %h", act, e); end
    drive(0, 32'h00002083, 32'h110, 3, 4); step();
    e = mk(0, 0, 0, 0, 1, 0, 0, 32'h110); checks++;
    if (act !== e) begin errors++; $display("FAIL load_bubble: got %h exp %h", act, e); end
    drive(1, 32'h7E209093, 32'h114, 3, 4); step();
    e = mk(1, 0, 0, 0, 1, 0, 1, 32'h114); checks++;
    if (act !== e) begin errors++; $display("FAIL slli_badf7: got %h exp %h", act, e); end
    drive(1, 32'hFFF00093, 32'h118, 3, 4); step();
    e = mk(1, 0, 3, 32'hFFFFFFFF, 1, 1, 0, 32'h118); checks++;
    if (act !== e) begin errors++; $display("FAIL addi_neg: got %h exp %h", act, e); end
  endtask
  task automatic test_stall_flush();
    drive(1, 32'h002081B3, 32'h200, 5, 7); step();
    e = mk(1, 0, 5, 7, 3, 1, 0, 32'h200);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      drive(1, $urandom, $urandom, $urandom, $urandom); step();
      checks++;
      if (act !== e) begin errors++; $display("FAIL stall_hold%0d: got %h exp %h", k, act, e); end
    end
    flush = 1; step();
    checks++;
    if (act !== exp_t'(0)) begin errors++; $display("FAIL flush_stall: got %h exp %h", act, exp_t'(0)); end
    flush = 0; stall = 0;
  endtask
  task automatic test_mid_reset();
    drive(1, 32'h40435293, 32'h300, 32'h80000000, 1); step();
    rst = 1; drive(1, 32'h002081B3, 32'h304, 5, 7); step();
    checks++;
    if (act !== exp_t'(0)) begin errors++; $display("FAIL mid_reset: got %h exp %h", act, exp_t'(0)); end
    rst = 0;
  endtask
  task automatic test_random();
    logic [6:0] opcs[6] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h33};
    logic [6:0] f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h00};
    exp_t model;
    logic [31:0] i;
    rst = 1; step(); rst = 0;
    model = '0;
    for (int n = 0; n < 400; n++) begin
      i = $urandom;
      if ($urandom_range(0, 7) != 0) i[6:0] = opcs[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) != 0) i[31:25] = f7s[$urandom_range(0, 3)];
      drive(1'($urandom_range(0, 5) != 0), i, $urandom, $urandom, $urandom);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      if (flush) model = '0;
      else if (!stall) model = ref_dec(id_valid, id_instr, id_pc, rs1, rs2);
      step();
      checks++;
      if (act !== model) begin errors++; $display("FAIL random%0d instr=%h: got %h exp %h", n, id_instr, act, model); end
    end
    stall = 0; flush = 0;
  endtask
  initial begin
    test_reset();
    test_op();
    test_upper();
    test_muldiv();
    test_illegal();
    test_stall_flush();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_id_ex.md
Name: alu_ctrl_id_ex

Overview:
- ID-side counterpart of the EX-stage ALU: the block that drives the ALU's DATA1/DATA2/SELECT inputs.
- Decodes RV32I/RV32M register-register, register-immediate, LUI and AUIPC instructions into the 5-bit ALU SELECT code and the two ALU operands.
- Holds the result in the ID/EX pipeline register, with stall, flush and a valid bit.
- Sits between the register file read and the ALU; its outputs feed the ALU directly.

Parameters:
- XLEN, 32, operand/PC width; only 32 is supported.
- SEL_W, 5, ALU SELECT width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  hold all ID/EX registers.
- FLUSH  in  1  insert a bubble into ID/EX.
- ID_VALID  in  1  ID holds a real instruction.
- ID_INSTR  in  32  instruction word.
- ID_PC  in  32  instruction PC.
- ID_RS1_DATA  in  32  register file rs1 value.
- ID_RS2_DATA  in  32  register file rs2 value.
- EX_VALID  out  1  registered valid.
- EX_ALU_SELECT  out  5  registered ALU SELECT.
- EX_DATA1  out  32  registered ALU operand A.
- EX_DATA2  out  32  registered ALU operand B.
- EX_RD  out  5  destination register.
- EX_REG_WRITE  out  1  write-back enable.
- EX_ILLEGAL  out  1  unsupported or illegal encoding.
- EX_PC  out  32  registered PC.

Behaviour:
- Clocking and reset: one clock (CLK); reset is synchronous, active-high (RESET).
- Reset: all outputs are 0. That means EX_VALID=0, EX_ALU_SELECT=ADD (5'b00000), EX_DATA1=EX_DATA2=EX_PC=0, EX_RD=0, EX_REG_WRITE=0, EX_ILLEGAL=0.
- Update priority, per edge: RESET > FLUSH > STALL > load.
  - FLUSH forces the reset values, even while STALL=1.
  - STALL holds every output.
  - Otherwise the block loads the decode of the ID inputs.
- Latency: 1 cycle from ID inputs to EX outputs. Decode is purely combinational ahead of the register.
- SELECT encoding (owned by the shared package, must match the ALU):
  - ADD 00000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100, SRL 00101, OR 00110, AND 00111
  - MUL 01000, MULH 01001, MULHSU 01010, MULHU 01011, DIV 01100, REM 01101, DIVU 01110, REMU 01111
  - SUB 10000, SRA 10001
- OP (0110011): DATA1=rs1, DATA2=rs2. The {funct7,funct3} pair selects the op:
  - funct7=0000000: base ops.
  - funct7=0100000 with funct3 000: SUB; with 101: SRA; with any other funct3: illegal.
  - funct7=0000001: M ops (see Optional Feature).
  - Any other funct7: illegal.
- OP-IMM (0010011): DATA1=rs1, DATA2=sign-extended imm[11:0].
  - SLLI/SRLI/SRAI: DATA2={27'b0,shamt}.
  - SLLI needs funct7=0000000.
  - SRLI/SRAI need funct7 = 0000000 / 0100000; anything else is illegal.
- LUI (0110111): DATA1=0, DATA2={imm[31:12],12'b0}, SELECT=ADD.
- AUIPC (0010111): DATA1=ID_PC, DATA2=U-imm, SELECT=ADD.
- Any other opcode: EX_ILLEGAL=1, SELECT=ADD, DATA1=DATA2=0.
- EX_REG_WRITE = ID_VALID & ~illegal & (rd != 0).
- EX_ILLEGAL is qualified by ID_VALID, so a bubble never flags illegal.
- EX_VALID = ID_VALID, which keeps a bubble flowing with write disabled.
- Inputs are assumed already forwarded; the block performs no hazard detection.

Optional Feature:
- Macro: RV32M_DECODE_EN.
- Defined: funct7=0000001 on OP decodes funct3 000..111 to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Undefined: those encodings set EX_ILLEGAL=1 and EX_REG_WRITE=0, with SELECT=ADD.

Decomposition:
- Package alu_pkg holds:
  - a typedef for the 5-bit SELECT;
  - one localparam per SELECT code;
  - opcode constants (OP, OP_IMM, LUI, AUIPC);
  - funct7 constants (BASE, ALT, MULDIV).
- Sub-module alu_op_decoder: purely combinational; instruction and PC/operands in, SELECT, operands, illegal flag and rd out.
- The top level holds only the ID/EX register and the stall/flush priority.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, ID_VALID=1 -> next cycle SELECT=00000, DATA1=5, DATA2=7, RD=3, REG_WRITE=1.
- srai x5,x6,4 (0x40435293), rs1=0x80000000 -> SELECT=10001, DATA2=4. Then sub (0x40208033) -> SELECT=10000, REG_WRITE=0 because rd=x0.
- auipc x1,0x12345 at PC=0x100 -> DATA1=0x100, DATA2=0x12345000, SELECT=ADD. Then lui -> DATA1=0.
- remu x4,x1,x2 (0x0220F233):
  - with RV32M_DECODE_EN -> SELECT=01111, ILLEGAL=0;
  - without it -> ILLEGAL=1, REG_WRITE=0.
- STALL=1 for 3 cycles while ID_INSTR changes -> outputs are held. Assert FLUSH together with STALL -> next cycle all outputs are 0.
- Assert RESET for one cycle mid-stream -> all outputs are 0 on that edge. Opcode 0000011 with ID_VALID=1 -> ILLEGAL=1; the same opcode with ID_VALID=0 -> ILLEGAL=0.
